// File: rtl/serial_alu_pkg.sv
// ============================================================================
//  Module      : serial_alu_pkg
//  Description : Shared types and constants for the bit-serial ALU sequencer:
//                opcode encoding, controller state encoding, default width
//                and a helper classifying the carry-propagating opcodes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_alu_pkg;

    localparam int SERIAL_ALU_DEFAULT_WIDTH = 64;

    typedef enum logic [2:0] {
        OP_PASS_B  = 3'b000,
        OP_ZERO    = 3'b001,
        OP_ADD     = 3'b010,
        OP_SUB     = 3'b011,
        OP_AND     = 3'b100,
        OP_OR      = 3'b101,
        OP_XOR     = 3'b110,
        OP_ZERO_HI = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_state_t;

    // Only ADD and SUB propagate a carry between bit slices.
    function automatic logic op_is_arith(alu_op_t op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_bit_op.sv
// ============================================================================
//  Module      : serial_bit_op
//  Description : Combinational one-bit ALU slice used by the serial sequencer.
//  Ports       : op   - operation (alu_op_t)
//                a, b - operand bits
//                cin  - carry in (meaningful for ADD/SUB only)
//                sum  - result bit
//                cout - carry out (0 for non-arithmetic ops)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_bit_op
    import serial_alu_pkg::*;
(
    input  alu_op_t op,
    input  logic    a,
    input  logic    b,
    input  logic    cin,
    output logic    sum,
    output logic    cout
);

    // SUB is a + ~b + 1; the +1 is supplied by the controller's initial carry.
    logic b_eff;
    assign b_eff = (op == OP_SUB) ? ~b : b;

    always_comb begin
        sum  = 1'b0;
        cout = 1'b0;
        case (op)
            OP_PASS_B: sum = b;
            OP_ADD, OP_SUB: begin
                sum  = a ^ b_eff ^ cin;
                cout = (a & b_eff) | (a & cin) | (b_eff & cin);
            end
            OP_AND:  sum = a & b;
            OP_OR:   sum = a | b;
            OP_XOR:  sum = a ^ b;
            default: sum = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/serial_alu_ctrl.sv
// ============================================================================
//  Module      : serial_alu_ctrl
//  Description : Bit-serial ALU sequencer. Captures one word-wide operation on
//                start, evaluates it LSB first over WIDTH cycles through a
//                single one-bit slice, then pulses done for one cycle.
//  Ports       : clk, reset (async, active-high)
//                start, op[2:0], a/b[WIDTH-1:0] - request and operands
//                busy, done                     - handshake status
//                result[WIDTH-1:0]              - held until next accepted start
//                zero, negative, overflow, carry_out - status flags
//  Build macro : SERIAL_ALU_FLAGS_EN - when defined, status flag logic is
//                built; otherwise all four flags are tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_alu_ctrl
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = SERIAL_ALU_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             overflow,
    output logic             carry_out
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    ctrl_state_t      state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [WIDTH-1:0] result_q, result_d;
    alu_op_t          op_q,     op_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             carry_q,  carry_d;

    logic start_acc;
    logic last_bit;
    logic bit_res;
    logic bit_cout;

    serial_bit_op u_bit_op (
        .op   (op_q),
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .sum  (bit_res),
        .cout (bit_cout)
    );

    assign last_bit = (state_q == RUN) && (cnt_q == LAST_IDX);

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        result_d  = result_q;
        start_acc = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    start_acc = 1'b1;
                end
            end
            RUN: begin
                // New bit enters at the MSB; after WIDTH shifts bit 0 of the
                // operands has landed in result[0].
                result_d = {bit_res, result_q[WIDTH-1:1]};
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                if (op_is_arith(op_q)) begin
                    carry_d = bit_cout;
                end
                if (last_bit) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    state_d   = RUN;
                    start_acc = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start_acc) begin
            a_d     = a;
            b_d     = b;
            op_d    = alu_op_t'(op);
            cnt_d   = '0;
            // Initial carry of 1 provides the +1 of two's-complement subtract.
            carry_d = (alu_op_t'(op) == OP_SUB);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_PASS_B;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign result = result_q;

`ifdef SERIAL_ALU_FLAGS_EN
    logic zacc_q;
    logic zero_q;
    logic neg_q;
    logic ovf_q;
    logic cout_q;

    // zacc_q ORs together every result bit produced so far, so zero can be
    // decided on the final bit without a WIDTH-wide compare.
    // carry_q during the final bit is the carry into the MSB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zacc_q <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
            cout_q <= 1'b0;
        end else begin
            if (start_acc) begin
                zacc_q <= 1'b0;
            end else if (state_q == RUN) begin
                zacc_q <= zacc_q | bit_res;
            end
            if (last_bit) begin
                zero_q <= ~(zacc_q | bit_res);
                neg_q  <= bit_res;
                cout_q <= op_is_arith(op_q) & bit_cout;
                ovf_q  <= op_is_arith(op_q) & (carry_q ^ bit_cout);
            end
        end
    end

    assign zero      = zero_q;
    assign negative  = neg_q;
    assign overflow  = ovf_q;
    assign carry_out = cout_q;
`else
    assign zero      = 1'b0;
    assign negative  = 1'b0;
    assign overflow  = 1'b0;
    assign carry_out = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_alu_ctrl.sv
// ============================================================================
//  Module      : tb_serial_alu_ctrl
//  Description : Self-checking bench for serial_alu_ctrl (WIDTH = 64).
//                Directed operations push hand-computed expectations into a
//                queue; a monitor pops and compares on every done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_alu_ctrl;

    localparam int W = 64;
`ifdef SERIAL_ALU_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         zero;
    logic         negative;
    logic         overflow;
    logic         carry_out;

    serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .zero      (zero),
        .negative  (negative),
        .overflow  (overflow),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   flags;    // {zero, negative, overflow, carry_out}
        int           done_cyc;
        string        name;
    } exp_t;

    exp_t sbq[$];
    exp_t m_e;
    int   checks = 0;
    int   errors = 0;

    // Scoreboard monitor
    always @(negedge clk) begin
        if (done) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done at cycle %0d: got done=1 required none", cyc);
            end else begin
                m_e = sbq.pop_front();
                checks++;
                if (result !== m_e.res) begin
                    errors++;
                    $display("FAIL %s result: got %h required %h", m_e.name, result, m_e.res);
                end
                checks++;
                if ({zero, negative, overflow, carry_out} !== m_e.flags) begin
                    errors++;
                    $display("FAIL %s flags{z,n,v,c}: got %b required %b", m_e.name,
                             {zero, negative, overflow, carry_out}, m_e.flags);
                end
                checks++;
                if (cyc != m_e.done_cyc) begin
                    errors++;
                    $display("FAIL %s latency: done at cycle %0d required %0d", m_e.name, cyc, m_e.done_cyc);
                end
            end
        end
    end

    // Caller is at a negedge; request is accepted at the following posedge.
    task automatic issue(input string name, input logic [2:0] o, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input logic [W-1:0] er, input logic [3:0] ef);
        exp_t e;
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.res      = er;
        e.flags    = FLAGS_ON ? ef : 4'b0000;
        e.done_cyc = cyc + W;
        e.name     = name;
        sbq.push_back(e);
        checks++;
        if (!(busy === 1'b1 && done === 1'b0)) begin
            errors++;
            $display("FAIL %s busy_after_accept: got busy=%b done=%b required busy=1 done=0", name, busy, done);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 3 * W && sbq.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending results required 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic [W-1:0] er, input logic [3:0] ef);
        @(negedge clk);
        issue(name, o, av, bv, er, ef);
        drain();
    endtask

    localparam logic [W-1:0] PAT_A = 64'hF0F0_F0F0_F0F0_F0F0;
    localparam logic [W-1:0] PAT_B = 64'hFF00_FF00_FF00_FF00;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 3'b000;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, result, zero, negative, overflow, carry_out} !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b result=%h flags=%b required all 0",
                     busy, done, result, {zero, negative, overflow, carry_out});
        end
        reset = 1'b0;

        // Arithmetic boundaries
        run_op("add_ovf",  3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 4'b0110);
        run_op("add_wrap", 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0,                   4'b1001);
        run_op("sub_5_5",  3'b011, 64'h5, 64'h5, 64'h0,                                      4'b1001);
        run_op("sub_0_1",  3'b011, 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF,                    4'b0100);

        // Logic, pass and zero opcodes
        run_op("and",    3'b100, PAT_A, PAT_B, 64'hF000_F000_F000_F000, 4'b0100);
        run_op("or",     3'b101, PAT_A, PAT_B, 64'hFFF0_FFF0_FFF0_FFF0, 4'b0100);
        run_op("xor",    3'b110, PAT_A, PAT_B, 64'h0FF0_0FF0_0FF0_0FF0, 4'b0000);
        run_op("pass_b", 3'b000, PAT_A, PAT_B, PAT_B,                  4'b0100);
        run_op("zero1",  3'b001, PAT_A, PAT_B, 64'h0,                  4'b1000);
        run_op("zero7",  3'b111, PAT_A, PAT_B, 64'h0,                  4'b1000);

        // Asynchronous reset mid-RUN: partial result discarded, no done
        @(negedge clk);
        start = 1'b1;
        op    = 3'b010;
        a     = 64'hFFFF_FFFF_FFFF_FFFF;
        b     = 64'h0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, result, zero, negative, overflow, carry_out} !== '0) begin
            errors++;
            $display("FAIL reset_mid_run: got busy=%b done=%b result=%h flags=%b required all 0",
                     busy, done, result, {zero, negative, overflow, carry_out});
        end
        @(negedge clk);
        reset = 1'b0;
        run_op("add_after_reset", 3'b010, 64'h3, 64'h4, 64'h7, 4'b0000);

        // start during RUN is ignored
        @(negedge clk);
        issue("add_ignore", 3'b010, 64'h10, 64'h20, 64'h30, 4'b0000);
        repeat (20) @(negedge clk);
        start = 1'b1;
        op    = 3'b110;
        a     = 64'hFFFF;
        b     = 64'h0;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (80) @(negedge clk);

        // Back-to-back: start in the DONE cycle
        @(negedge clk);
        issue("b2b_sub", 3'b011, 64'h100, 64'h1, 64'hFF, 4'b0001);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < W + 10 && !seen; i++) begin
                @(negedge clk);
                if (done) seen = 1'b1;
            end
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL b2b_first_done: got no done required done within %0d cycles", W + 10);
            end
        end
        issue("b2b_add", 3'b010, 64'h1, 64'h1, 64'h2, 4'b0000);
        drain();

        // result held stable in IDLE
        begin
            int bad = 0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (result !== 64'h2 || busy !== 1'b0) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL idle_hold: got %0d unstable cycles (result=%h) required 0 with result=2", bad, result);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
